// File: rtl/regm_rd_arb.sv
// regm_rd_arb: shares the sensor register table's single read port among
// N_REQ requesters. Requesters are granted round-robin, and only one lookup
// is in flight at a time because a new strobe restarts the table's delay.
// A lookup that gets no reply is abandoned after TIMEOUT wait cycles, and the
// requester then receives zero data with the error flag set.
module regm_rd_arb #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [N_REQ-1:0]     rq_valid,
  input  logic [8*N_REQ-1:0]   rq_id,
  output logic [N_REQ-1:0]     rq_done,
  output logic                 rq_err,
  output logic [31:0]          rq_data,
  output logic                 req_id_f,
  output logic [7:0]           req_id,
  input  logic                 req_data_f,
  input  logic [31:0]          req_data
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state, w_state_next;
  logic [PW-1:0]    r_ptr, w_ptr_next;
  logic [PW-1:0]    r_win, w_win_next;
  logic [7:0]       r_cnt, w_cnt_next;
  logic [N_REQ-1:0] r_done, w_done_next;
  logic             r_err, w_err_next;
  logic [31:0]      r_data, w_data_next;
  logic             r_id_f, w_id_f_next;
  logic [7:0]       r_req_id, w_req_id_next;

  logic [7:0]       w_id [N_REQ];
  logic [PW-1:0]    w_rot_idx [N_REQ];
  logic [N_REQ-1:0] w_rot_valid;
  logic [PW-1:0]    w_pick;
  logic [PW-1:0]    w_pick_inc;
  logic             w_any;
  logic [N_REQ-1:0] w_win_onehot;

  // Per-requester id slices and the request vector rotated so that
  // position 0 is the requester the round-robin pointer currently favours.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      logic [PW:0] w_sum;
      assign w_id[gi]        = rq_id[8*gi +: 8];
      assign w_sum           = {1'b0, r_ptr} + (PW+1)'(gi);
      assign w_rot_idx[gi]   = (w_sum >= (PW+1)'(N_REQ)) ?
                               PW'(w_sum - (PW+1)'(N_REQ)) : w_sum[PW-1:0];
      assign w_rot_valid[gi] = rq_valid[w_rot_idx[gi]];
    end
  endgenerate

  // The lowest rotated position holding a request wins the grant.
  always_comb begin
    w_pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot_valid[k]) w_pick = w_rot_idx[k];
    end
  end

  assign w_any        = |rq_valid;
  assign w_pick_inc   = (w_pick == PW'(N_REQ - 1)) ? '0 : w_pick + PW'(1);
  assign w_win_onehot = N_REQ'(1) << r_win;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_next  = r_state;
    w_ptr_next    = r_ptr;
    w_win_next    = r_win;
    w_cnt_next    = r_cnt;
    w_done_next   = '0;
    w_err_next    = 1'b0;
    w_data_next   = r_data;
    w_id_f_next   = 1'b0;
    w_req_id_next = r_req_id;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_win_next    = w_pick;
          w_req_id_next = w_id[w_pick];
          w_ptr_next    = w_pick_inc;
          w_id_f_next   = 1'b1;
          w_state_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_next   = '0;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // A reply in the final wait cycle still wins over the timeout.
        if (req_data_f) begin
          w_data_next  = req_data;
          w_done_next  = w_win_onehot;
          w_err_next   = 1'b0;
          w_state_next = S_RESP;
        end else if (r_cnt == 8'(TIMEOUT)) begin
          w_data_next  = '0;
          w_done_next  = w_win_onehot;
          w_err_next   = 1'b1;
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any lookup in progress.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_cnt    <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_data   <= '0;
      r_id_f   <= 1'b0;
      r_req_id <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_win    <= w_win_next;
      r_cnt    <= w_cnt_next;
      r_done   <= w_done_next;
      r_err    <= w_err_next;
      r_data   <= w_data_next;
      r_id_f   <= w_id_f_next;
      r_req_id <= w_req_id_next;
    end
  end

  assign rq_done  = r_done;
  assign rq_err   = r_err;
  assign rq_data  = r_data;
  assign req_id_f = r_id_f;
  assign req_id   = r_req_id;

endmodule

// File: tb/tb_regm_rd_arb.sv
// Bench for regm_rd_arb: a behavioural register-table responder plus a
// round-robin / latency reference model; each test task checks inline.
module tb_regm_rd_arb;
  localparam int N  = 4;
  localparam int TO = 15;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic [N-1:0]   rq_valid;
  logic [8*N-1:0] rq_id;
  logic [N-1:0]   rq_done;
  logic           rq_err;
  logic [31:0]    rq_data;
  logic           req_id_f;
  logic [7:0]     req_id;
  logic           req_data_f;
  logic [31:0]    req_data;

  logic           tbl_f, stray_f;
  logic [31:0]    tbl_data, stray_data;
  assign req_data_f = tbl_f | stray_f;
  assign req_data   = stray_f ? stray_data : tbl_data;

  logic [N-1:0]   rq_valid4;
  logic [8*N-1:0] rq_id4;
  logic [N-1:0]   rq_done4;
  logic           rq_err4;
  logic [31:0]    rq_data4;
  logic           req_id_f4;
  logic [7:0]     req_id4;
  logic           req_data_f4;
  logic [31:0]    req_data4;

  regm_rd_arb #(.N_REQ(N), .TIMEOUT(TO)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rq_valid(rq_valid), .rq_id(rq_id),
    .rq_done(rq_done), .rq_err(rq_err), .rq_data(rq_data), .req_id_f(req_id_f),
    .req_id(req_id), .req_data_f(req_data_f), .req_data(req_data));

  regm_rd_arb #(.N_REQ(N), .TIMEOUT(4)) u_dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rq_valid(rq_valid4), .rq_id(rq_id4),
    .rq_done(rq_done4), .rq_err(rq_err4), .rq_data(rq_data4), .req_id_f(req_id_f4),
    .req_id(req_id4), .req_data_f(req_data_f4), .req_data(req_data4));

  int          n_vec = 0;
  int          n_err = 0;
  int          m_ptr = 0;
  logic [31:0] m_data = '0;
  logic [31:0] tbl_mem [256];
  int          tbl_dly = 4;
  bit          tbl_silent = 0;
  int          tbl_cnt = -1;
  logic [7:0]  tbl_id = '0;
  logic [7:0]  ids [N];

  // Register table: replies tbl_dly cycles after the strobe cycle.
  initial begin
    tbl_f = 1'b0;
    tbl_data = '0;
    forever begin
      @(posedge sys_clk); #1;
      tbl_f = 1'b0;
      if (tbl_cnt > 0) begin
        tbl_cnt--;
        if (tbl_cnt == 0) begin
          tbl_f    = !tbl_silent;
          tbl_data = tbl_mem[tbl_id];
          tbl_cnt  = -1;
        end
      end
      if (req_id_f) begin
        tbl_cnt = tbl_dly;
        tbl_id  = req_id;
      end
    end
  end

  function automatic int rr_pick(input int ptr, input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic drive_ids();
    for (int i = 0; i < N; i++) rq_id[8*i +: 8] = ids[i];
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1; rq_valid = '0;
    step(); step();
    sys_rst = 1'b0;
    step();
    m_ptr = 0; m_data = '0;
  endtask

  // Runs one grant from the current IDLE cycle (c0) and records what is seen.
  task automatic run_grant(input int drop_cyc, input logic [N-1:0] drop_mask,
                           output int t_f, output logic [7:0] o_id, output int n_f,
                           output int t_done, output logic [N-1:0] o_done,
                           output logic [31:0] o_data, output logic o_err);
    t_f = -1; o_id = '0; n_f = 0; t_done = -1; o_done = '0; o_data = '0; o_err = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      step();
      if (cyc == drop_cyc) rq_valid = rq_valid & ~drop_mask;
      if (req_id_f) begin
        n_f++;
        if (t_f < 0) begin t_f = cyc; o_id = req_id; end
      end
      if (rq_done !== '0) begin
        t_done = cyc; o_done = rq_done; o_data = rq_data; o_err = rq_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; rq_valid = '0; rq_id = '0; stray_f = 1'b0; stray_data = '0;
    rq_valid4 = '0; rq_id4 = '0; req_data_f4 = 1'b0; req_data4 = '0;
    for (int i = 0; i < 256; i++) tbl_mem[i] = (i < 64) ? $urandom : 32'h0;
    tbl_mem[5] = 32'hDEAD_BEEF;
    repeat (3) step();
    n_vec++; if (rq_done !== '0) begin n_err++; $display("FAIL reset_done: got %b want 0", rq_done); end
    n_vec++; if (rq_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", rq_err); end
    n_vec++; if (rq_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", rq_data); end
    n_vec++; if (req_id_f !== 1'b0) begin n_err++; $display("FAIL reset_id_f: got %b want 0", req_id_f); end
    n_vec++; if (req_id !== '0) begin n_err++; $display("FAIL reset_id: got %h want 0", req_id); end
    sys_rst = 1'b0;
    step();
    n_vec++; if (req_id_f !== 1'b0) begin n_err++; $display("FAIL idle_id_f: got %b want 0", req_id_f); end
    m_ptr = 0; m_data = '0;
  endtask

  task automatic test_single();
    int t_f, n_f, t_d; logic [7:0] o_id; logic [N-1:0] o_dn; logic [31:0] o_dt; logic o_e;
    tbl_dly = 4; tbl_silent = 0;
    ids[2] = 8'h05; drive_ids();
    rq_valid = 4'b0100;
    run_grant(0, '0, t_f, o_id, n_f, t_d, o_dn, o_dt, o_e);
    $display("single: id_f@%0d id=%h done@%0d %b data=%h err=%b", t_f, o_id, t_d, o_dn, o_dt, o_e);
    n_vec++; if (t_f !== 1) begin n_err++; $display("FAIL single_idf_cyc: got %0d want 1", t_f); end
    n_vec++; if (o_id !== 8'h05) begin n_err++; $display("FAIL single_id: got %h want 05", o_id); end
    n_vec++; if (n_f !== 1) begin n_err++; $display("FAIL single_nf: got %0d want 1", n_f); end
    n_vec++; if (t_d !== 6) begin n_err++; $display("FAIL single_done_cyc: got %0d want 6", t_d); end
    n_vec++; if (o_dn !== 4'b0100) begin n_err++; $display("FAIL single_done: got %b want 0100", o_dn); end
    n_vec++; if (o_dt !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", o_dt); end
    n_vec++; if (o_e !== 1'b0) begin n_err++; $display("FAIL single_err: got %b want 0", o_e); end
    rq_valid = '0; m_ptr = 3; m_data = 32'hDEAD_BEEF;
    step();
    n_vec++; if (rq_done !== '0) begin n_err++; $display("FAIL single_done_pulse: got %b want 0", rq_done); end
    n_vec++; if (rq_data !== m_data) begin n_err++; $display("FAIL single_hold: got %h want %h", rq_data, m_data); end
  endtask

  task automatic test_round_robin();
    int ord [6] = '{0, 1, 2, 3, 1, 3};
    int t_f, n_f, t_d; logic [7:0] o_id; logic [N-1:0] o_dn; logic [31:0] o_dt; logic o_e;
    apply_reset();
    for (int i = 0; i < N; i++) ids[i] = 8'(16 + i);
    drive_ids();
    rq_valid = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      if (g == 4) rq_valid = 4'b1010;
      run_grant(0, '0, t_f, o_id, n_f, t_d, o_dn, o_dt, o_e);
      $display("rr[%0d]: done@%0d %b id=%h data=%h", g, t_d, o_dn, o_id, o_dt);
      n_vec++; if (o_dn !== 4'(1 << ord[g])) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", g, o_dn, 4'(1 << ord[g])); end
      n_vec++; if (o_id !== ids[ord[g]]) begin n_err++; $display("FAIL rr_id%0d: got %h want %h", g, o_id, ids[ord[g]]); end
      n_vec++; if (n_f !== 1) begin n_err++; $display("FAIL rr_nf%0d: got %0d want 1", g, n_f); end
      n_vec++; if (t_d !== 6) begin n_err++; $display("FAIL rr_lat%0d: got %0d want 6", g, t_d); end
      n_vec++; if (o_dt !== tbl_mem[ids[ord[g]]]) begin n_err++; $display("FAIL rr_data%0d: got %h want %h", g, o_dt, tbl_mem[ids[ord[g]]]); end
      rq_valid[ord[g]] = 1'b0;
      m_ptr = (ord[g] + 1) % N; m_data = tbl_mem[ids[ord[g]]];
      step();
    end
  endtask

  task automatic test_timeout();
    int t_f, n_f, t_d; logic [7:0] o_id; logic [N-1:0] o_dn; logic [31:0] o_dt; logic o_e;
    tbl_silent = 1; ids[0] = 8'h07; drive_ids();
    rq_valid = 4'b0001;
    run_grant(0, '0, t_f, o_id, n_f, t_d, o_dn, o_dt, o_e);
    $display("timeout: done@%0d %b data=%h err=%b", t_d, o_dn, o_dt, o_e);
    n_vec++; if (t_d !== 2 + TO + 1) begin n_err++; $display("FAIL to_cyc: got %0d want %0d", t_d, 2 + TO + 1); end
    n_vec++; if (o_dn !== 4'b0001) begin n_err++; $display("FAIL to_done: got %b want 0001", o_dn); end
    n_vec++; if (o_e !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", o_e); end
    n_vec++; if (o_dt !== '0) begin n_err++; $display("FAIL to_data: got %h want 0", o_dt); end
    n_vec++; if (n_f !== 1) begin n_err++; $display("FAIL to_nf: got %0d want 1", n_f); end
    rq_valid = '0; m_ptr = 1; m_data = '0;
    step();
    n_vec++; if (rq_err !== 1'b0) begin n_err++; $display("FAIL to_err_pulse: got %b want 0", rq_err); end
    tbl_silent = 0;
    rq_valid = 4'b0001;
    run_grant(0, '0, t_f, o_id, n_f, t_d, o_dn, o_dt, o_e);
    $display("after timeout: done@%0d %b data=%h err=%b", t_d, o_dn, o_dt, o_e);
    n_vec++; if (t_d !== 6) begin n_err++; $display("FAIL rec_cyc: got %0d want 6", t_d); end
    n_vec++; if (o_e !== 1'b0) begin n_err++; $display("FAIL rec_err: got %b want 0", o_e); end
    n_vec++; if (o_dt !== tbl_mem[8'h07]) begin n_err++; $display("FAIL rec_data: got %h want %h", o_dt, tbl_mem[8'h07]); end
    rq_valid = '0; m_ptr = 1; m_data = tbl_mem[8'h07];
    step();
  endtask

  task automatic test_stray();
    stray_data = 32'h1234_5678; stray_f = 1'b1;
    step();
    stray_f = 1'b0;
    $display("stray: reply pulsed while idle");
    for (int c = 0; c < 3; c++) begin
      step();
      n_vec++; if (rq_done !== '0) begin n_err++; $display("FAIL stray_done%0d: got %b want 0", c, rq_done); end
      n_vec++; if (rq_data !== m_data) begin n_err++; $display("FAIL stray_data%0d: got %h want %h", c, rq_data, m_data); end
      n_vec++; if (req_id_f !== 1'b0) begin n_err++; $display("FAIL stray_idf%0d: got %b want 0", c, req_id_f); end
    end
  endtask

  task automatic test_drop();
    int t_f, n_f, t_d; logic [7:0] o_id; logic [N-1:0] o_dn; logic [31:0] o_dt; logic o_e;
    ids[1] = 8'h21; drive_ids();
    rq_valid = 4'b0010;
    run_grant(2, 4'b0010, t_f, o_id, n_f, t_d, o_dn, o_dt, o_e);
    $display("drop: done@%0d %b data=%h", t_d, o_dn, o_dt);
    n_vec++; if (t_d !== 6) begin n_err++; $display("FAIL drop_cyc: got %0d want 6", t_d); end
    n_vec++; if (o_dn !== 4'b0010) begin n_err++; $display("FAIL drop_done: got %b want 0010", o_dn); end
    n_vec++; if (o_dt !== tbl_mem[8'h21]) begin n_err++; $display("FAIL drop_data: got %h want %h", o_dt, tbl_mem[8'h21]); end
    rq_valid = '0; m_ptr = 2; m_data = tbl_mem[8'h21];
    step(); step();
    n_vec++; if (req_id_f !== 1'b0) begin n_err++; $display("FAIL drop_regrant: got %b want 0", req_id_f); end
  endtask

  task automatic test_coincide();
    int t_f, n_f, t_d, t4; logic [7:0] o_id; logic [N-1:0] o_dn, d4; logic [31:0] o_dt, dt4; logic o_e, e4;
    ids[3] = 8'h30; drive_ids();
    for (int pass = 0; pass < 2; pass++) begin
      tbl_dly = TO + 1 + pass;
      rq_valid = 4'b1000;
      run_grant(0, '0, t_f, o_id, n_f, t_d, o_dn, o_dt, o_e);
      $display("edge dly=%0d: done@%0d data=%h err=%b", tbl_dly, t_d, o_dt, o_e);
      n_vec++; if (t_d !== 2 + TO + 1) begin n_err++; $display("FAIL edge_cyc%0d: got %0d want %0d", pass, t_d, 2 + TO + 1); end
      n_vec++; if (o_e !== 1'(pass)) begin n_err++; $display("FAIL edge_err%0d: got %b want %0d", pass, o_e, pass); end
      n_vec++; if (o_dt !== ((pass == 0) ? tbl_mem[8'h30] : 32'h0)) begin n_err++; $display("FAIL edge_data%0d: got %h", pass, o_dt); end
      rq_valid = '0; m_ptr = 0; m_data = o_dt;
      step(); step();
    end
    tbl_dly = 4;
    for (int pass = 0; pass < 2; pass++) begin
      rq_valid4 = 4'b0010; rq_id4 = 32'h0000_3300;
      t4 = -1; d4 = '0; dt4 = '0; e4 = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
        step();
        req_data_f4 = (cyc == ((pass == 0) ? 6 : 7));
        req_data4   = (pass == 0) ? 32'hCAFE_F00D : 32'h5555_AAAA;
        if (rq_done4 !== '0 && t4 < 0) begin
          t4 = cyc; d4 = rq_done4; dt4 = rq_data4; e4 = rq_err4; rq_valid4 = '0;
        end
      end
      req_data_f4 = 1'b0;
      $display("to4 pass%0d: done@%0d %b data=%h err=%b", pass, t4, d4, dt4, e4);
      n_vec++; if (t4 !== 7) begin n_err++; $display("FAIL to4_cyc%0d: got %0d want 7", pass, t4); end
      n_vec++; if (d4 !== 4'b0010) begin n_err++; $display("FAIL to4_done%0d: got %b want 0010", pass, d4); end
      n_vec++; if (e4 !== 1'(pass)) begin n_err++; $display("FAIL to4_err%0d: got %b want %0d", pass, e4, pass); end
      n_vec++; if (dt4 !== ((pass == 0) ? 32'hCAFE_F00D : 32'h0)) begin n_err++; $display("FAIL to4_data%0d: got %h", pass, dt4); end
      n_vec++; if (rq_data4 !== dt4 || rq_done4 !== '0) begin n_err++; $display("FAIL to4_hold%0d: got %h/%b want %h/0", pass, rq_data4, rq_done4, dt4); end
    end
  endtask

  task automatic test_reset_mid();
    int t_f, n_f, t_d; logic [7:0] o_id; logic [N-1:0] o_dn; logic [31:0] o_dt; logic o_e;
    int bad;
    ids[2] = 8'h05; drive_ids();
    rq_valid = 4'b0100;
    step();
    n_vec++; if (req_id_f !== 1'b1) begin n_err++; $display("FAIL rmid_idf: got %b want 1", req_id_f); end
    step(); step();
    sys_rst = 1'b1; rq_valid = '0;
    #1;
    n_vec++; if ({rq_done, rq_err, req_id_f, req_id, rq_data} !== '0) begin n_err++; $display("FAIL rmid_async: got %b %b %b %h %h want all 0", rq_done, rq_err, req_id_f, req_id, rq_data); end
    step();
    sys_rst = 1'b0;
    bad = 0;
    for (int cyc = 5; cyc <= 12; cyc++) begin
      step();
      if ({rq_done, rq_err, req_id_f, req_id, rq_data} !== '0) bad++;
    end
    $display("reset mid-wait: nonzero-output cycles=%0d", bad);
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rmid_quiet: got %0d active cycles want 0", bad); end
    m_ptr = 0; m_data = '0;
    for (int i = 0; i < N; i++) ids[i] = 8'(40 + i);
    drive_ids();
    rq_valid = 4'b1111;
    run_grant(0, '0, t_f, o_id, n_f, t_d, o_dn, o_dt, o_e);
    $display("after reset: done@%0d %b", t_d, o_dn);
    n_vec++; if (o_dn !== 4'b0001) begin n_err++; $display("FAIL rmid_ptr: got %b want 0001", o_dn); end
    rq_valid = '0; m_ptr = 1; m_data = o_dt;
    step();
  endtask

  task automatic test_random();
    int t_f, n_f, t_d, exp_w, exp_t; logic [7:0] o_id; logic [N-1:0] o_dn, mask;
    logic [31:0] o_dt, exp_d; logic o_e, exp_e;
    mask = '0;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!mask[i] && $urandom_range(0, 1) == 1) begin
          mask[i] = 1'b1;
          ids[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
        end
      end
      if (mask == '0) begin
        mask[0] = 1'b1; ids[0] = 8'($urandom_range(0, 63));
      end
      drive_ids();
      rq_valid = mask;
      tbl_dly = $urandom_range(1, TO + 3);
      exp_w = rr_pick(m_ptr, mask);
      if (tbl_dly <= TO + 1) begin
        exp_t = tbl_dly + 2; exp_d = tbl_mem[ids[exp_w]]; exp_e = 1'b0;
      end else begin
        exp_t = 2 + TO + 1; exp_d = '0; exp_e = 1'b1;
      end
      run_grant(0, '0, t_f, o_id, n_f, t_d, o_dn, o_dt, o_e);
      $display("rand[%0d]: mask=%b dly=%0d done@%0d %b id=%h data=%h err=%b", it, mask, tbl_dly, t_d, o_dn, o_id, o_dt, o_e);
      n_vec++; if (o_dn !== 4'(1 << exp_w)) begin n_err++; $display("FAIL rnd_grant%0d: got %b want %b", it, o_dn, 4'(1 << exp_w)); end
      n_vec++; if (o_id !== ids[exp_w]) begin n_err++; $display("FAIL rnd_id%0d: got %h want %h", it, o_id, ids[exp_w]); end
      n_vec++; if (t_f !== 1 || n_f !== 1) begin n_err++; $display("FAIL rnd_strobe%0d: got at %0d x%0d want at 1 x1", it, t_f, n_f); end
      n_vec++; if (t_d !== exp_t) begin n_err++; $display("FAIL rnd_cyc%0d: got %0d want %0d", it, t_d, exp_t); end
      n_vec++; if (o_dt !== exp_d) begin n_err++; $display("FAIL rnd_data%0d: got %h want %h", it, o_dt, exp_d); end
      n_vec++; if (o_e !== exp_e) begin n_err++; $display("FAIL rnd_err%0d: got %b want %b", it, o_e, exp_e); end
      mask[exp_w] = 1'b0;
      rq_valid = mask;
      m_ptr = (exp_w + 1) % N; m_data = exp_d;
      step();
    end
    rq_valid = '0;
    tbl_dly = 4;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stray();
    test_drop();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regm_rd_arb.md
# regm_rd_arb

Read-port arbiter for the sensor register table. Several transmit-side requesters share the table's single read port (`req_id_f`/`req_id` -> `req_data_f`/`req_data`). The arbiter grants requesters in round-robin order and keeps at most one lookup outstanding, because a new `req_id_f` restarts the table's internal delay. Each reply is returned to the granted requester, and a timeout recovers from a missing reply.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 15: WAIT cycles allowed before abandoning a lookup (1..255).
- Clocking: one clock; reset is asynchronous and active-high.
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  asynchronous reset, active-high.
- `rq_valid`  in  N_REQ  per-requester request level; held until that requester's `rq_done` bit pulses.
- `rq_id`  in  8*N_REQ  requester i's register id in bits [8i+7:8i]; stable while `rq_valid[i]`.
- `rq_done`  out  N_REQ  one-hot, one-cycle completion pulse.
- `rq_err`  out  1  one-cycle pulse coincident with `rq_done` when the lookup timed out.
- `rq_data`  out  32  reply data; valid in the `rq_done` cycle and held until the next completion.
- `req_id_f`  out  1  one-cycle lookup strobe to the register table.
- `req_id`  out  8  lookup id; held from the strobe until the next grant.
- `req_data_f`  in  1  one-cycle reply strobe from the register table.
- `req_data`  in  32  reply data, sampled when `req_data_f`=1.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `rq_valid` is set, pick a winner by round-robin.
  - Search starts at index `ptr`. The first set bit at or after `ptr` wins, wrapping modulo N_REQ.
  - Latch the winner's index and its `rq_id` into `req_id`. Set `ptr` = winner+1 (mod N_REQ). Go to ISSUE.
  - If no `rq_valid` is set, stay in IDLE.
- ISSUE: `req_id_f`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - If `req_data_f`=1: capture `req_data` into `rq_data`, clear the error flag, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: set `rq_data`=0, set the error flag, go to RESP.
  - `req_data_f` takes priority over timeout expiry in the same cycle.
- RESP: `rq_done[winner]`=1 and `rq_err`=error flag, for one cycle. Go to IDLE.
- `req_data_f` outside WAIT is ignored; it causes no state change and no data capture.
- The id is not range-checked. Out-of-table ids are forwarded unchanged, and whatever the table returns (zero) is delivered.
- If the winner drops `rq_valid` mid-transaction, the lookup still completes and the `rq_done` pulse is still issued.
- Requesters must deassert `rq_valid` (or present a new id) in the cycle after `rq_done`. IDLE re-samples `rq_valid` in that cycle.
- Reset values:
  - state IDLE, `ptr`=0, counter 0.
  - `rq_done`=0, `rq_err`=0, `rq_data`=0.
  - `req_id_f`=0, `req_id`=0.
- Reset asserted mid-transaction aborts it immediately: no `rq_done` is issued, and any later `req_data_f` is ignored.

## Timing
- All outputs are registered.
- Let c0 be the IDLE cycle that sees `rq_valid`.
  - `req_id_f`/`req_id` are high in c1.
  - WAIT starts in c2.
  - If `req_data_f` arrives in cycle cw, then `rq_done`/`rq_data` appear in cw+1, and IDLE is back in cw+2.
- With the table's reply one cycle after `dly_end` (`req_data_f` at c1+4 = c5), `rq_done` occurs at c6. Request-to-done latency is 6 cycles, and back-to-back service is one grant per 7 cycles.
- Timeout: with no reply, `rq_done`+`rq_err` occur at c2+TIMEOUT+1. With the default, that is c18.
- The arbiter never issues a second `req_id_f` before the previous lookup completes or times out.

## Test plan
- Single request: `rq_valid[2]`=1, `rq_id[2]`=8'h05, table model reg5=32'hDEAD_BEEF, 4-cycle reply -> `req_id_f` at c1 with `req_id`=05; `rq_done`=4'b0100 at c6; `rq_data`=DEADBEEF; `rq_err`=0.
- Round-robin: all four valid from reset, each dropped after its own done -> grant order 0,1,2,3. Then re-assert 1 and 3 -> order 1,3. Exactly one `req_id_f` per grant.
- Timeout: table model silent, `rq_valid[0]`=1 -> `rq_done[0]`=1, `rq_err`=1, `rq_data`=0 at c18; next request served normally.
- Stray reply: pulse `req_data_f` with `req_data`=32'h1234_5678 while IDLE -> `rq_data` unchanged, no `rq_done`.
- Reset mid-WAIT: assert `sys_rst` at c3 of a lookup, release, then deliver late `req_data_f` -> no `rq_done`, all outputs 0, `ptr` back at 0.
- Reply and timeout in the same cycle: TIMEOUT=4 with reply timed to coincide -> data delivered, `rq_err`=0.
